// File: rtl/divider_param.sv
// Parametrised multi-cycle restoring divider with optional two's-complement mode.
// One result every WIDTH+1 cycles; results and divide-by-zero flag are held until the next done.
module divider_param #(
    parameter int WIDTH     = 10,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_mode_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   work_q;
    logic [2*WIDTH-1:0]   work_d;
    logic [WIDTH-1:0]     divisorMag_q;
    logic [WIDTH-1:0]     origDividend_q;
    logic                 negQuot_q;
    logic                 negRem_q;
    logic                 zero_q;
    logic [WIDTH-1:0]     quot_q;
    logic [WIDTH-1:0]     quot_d;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     rem_d;
    logic                 dbz_q;
    logic                 done_q;

    logic                 modeSigned;
    logic                 dividendNeg;
    logic                 divisorNeg;
    logic [WIDTH-1:0]     dividendMag;
    logic [WIDTH-1:0]     divisorMag;
    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       diff;
    logic [WIDTH-1:0]     quotMag;
    logic [WIDTH-1:0]     remMag;

    // With SIGNED_EN=0 the sign terms are constant zero and the negation muxes vanish.
    assign modeSigned  = signed_mode_i & SIGNED_EN;
    assign dividendNeg = modeSigned & dividend_i[WIDTH-1];
    assign divisorNeg  = modeSigned & divisor_i[WIDTH-1];
    assign dividendMag = dividendNeg ? -dividend_i : dividend_i;
    assign divisorMag  = divisorNeg  ? -divisor_i  : divisor_i;

    // Upper WIDTH+1 bits of the register shifted left by one, minus the divisor.
    assign trial = work_q[2*WIDTH-1:WIDTH-1];
    assign diff  = trial - {1'b0, divisorMag_q};

    always_comb begin
        work_d = {work_q[2*WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            work_d = {diff[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
        end
    end

    assign quotMag = work_q[WIDTH-1:0];
    assign remMag  = work_q[2*WIDTH-1:WIDTH];

    // MIN / -1 needs no special case: |MIN| negated modulo 2^WIDTH is MIN again.
    always_comb begin
        quot_d = negQuot_q ? -quotMag : quotMag;
        rem_d  = negRem_q  ? -remMag  : remMag;
        if (zero_q) begin
            quot_d = '1;
            rem_d  = origDividend_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            work_q         <= '0;
            divisorMag_q   <= '0;
            origDividend_q <= '0;
            negQuot_q      <= 1'b0;
            negRem_q       <= 1'b0;
            zero_q         <= 1'b0;
            quot_q         <= '0;
            rem_q          <= '0;
            dbz_q          <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        negQuot_q      <= dividendNeg ^ divisorNeg;
                        negRem_q       <= dividendNeg;
                        zero_q         <= (divisor_i == '0);
                        origDividend_q <= dividend_i;
                        divisorMag_q   <= divisorMag;
                        work_q         <= {{WIDTH{1'b0}}, dividendMag};
                        cnt_q          <= CW'(WIDTH);
                        state_q        <= RUN;
                    end
                end
                RUN: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    quot_q  <= quot_d;
                    rem_q   <= rem_d;
                    dbz_q   <= zero_q;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o       = (state_q == IDLE);
    assign done_o        = done_q;
    assign quotient_o    = quot_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_divider_param.sv
// Scoreboard bench for divider_param: a 10-bit signed-capable unit and a 16-bit unsigned-only unit.
// Expected results are queued at each accepted start and compared when done pulses.
module tb_divider_param;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
    } expT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start10 = 1'b0;
    logic        sm10 = 1'b0;
    logic [9:0]  dvd10 = '0;
    logic [9:0]  dvs10 = '0;
    logic        ready10;
    logic        done10;
    logic [9:0]  q10;
    logic [9:0]  r10;
    logic        z10;

    logic        start16 = 1'b0;
    logic        sm16 = 1'b0;
    logic [15:0] dvd16 = '0;
    logic [15:0] dvs16 = '0;
    logic        ready16;
    logic        done16;
    logic [15:0] q16;
    logic [15:0] r16;
    logic        z16;

    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    expT sb10[$];
    expT sb16[$];

    divider_param #(.WIDTH(10), .SIGNED_EN(1'b1)) dut10 (
        .clk_i(clk), .rst_i(rst), .start_i(start10), .signed_mode_i(sm10),
        .dividend_i(dvd10), .divisor_i(dvs10), .ready_o(ready10), .done_o(done10),
        .quotient_o(q10), .remainder_o(r10), .div_by_zero_o(z10)
    );

    divider_param #(.WIDTH(16), .SIGNED_EN(1'b0)) dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start16), .signed_mode_i(sm16),
        .dividend_i(dvd16), .divisor_i(dvs16), .ready_o(ready16), .done_o(done16),
        .quotient_o(q16), .remainder_o(r16), .div_by_zero_o(z16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Truncating division on sign-extended 64-bit values, masked back to w bits.
    function automatic expT model(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        expT         e;
        longint      sa;
        longint      sb;
        longint      qq;
        longint      rr;
        logic [63:0] mask;
        logic [63:0] qv;
        logic [63:0] rv;
        mask  = (64'd1 << w) - 64'd1;
        e.cyc = 0;
        if (b == 32'd0) begin
            e.q = mask[31:0];
            e.r = a;
            e.z = 1'b1;
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
            if (sgn && a[w-1]) sa = sa - longint'(64'd1 << w);
            if (sgn && b[w-1]) sb = sb - longint'(64'd1 << w);
            qq  = sa / sb;
            rr  = sa % sb;
            qv  = 64'(qq) & mask;
            rv  = 64'(rr) & mask;
            e.q = qv[31:0];
            e.r = rv[31:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] pick(input int w);
        logic [31:0] mask;
        logic [31:0] minV;
        mask = (32'd1 << w) - 32'd1;
        minV = 32'd1 << (w - 1);
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return minV;
            3:       return minV - 32'd1;
            4:       return mask;
            default: return $urandom() & mask;
        endcase
    endfunction

    // Called at a negedge; drives one start, returns at the negedge after the accept edge.
    task automatic applyStimulus(input int u, input bit sm, input logic [31:0] a, input logic [31:0] b, input expT e);
        bit acc;
        if (u == 0) begin
            start10 = 1'b1; sm10 = sm; dvd10 = a[9:0]; dvs10 = b[9:0];
            acc = ready10 && !rst;
        end else begin
            start16 = 1'b1; sm16 = sm; dvd16 = a[15:0]; dvs16 = b[15:0];
            acc = ready16 && !rst;
        end
        @(posedge clk);
        #1;
        start10 = 1'b0;
        start16 = 1'b0;
        if (acc) begin
            e.cyc = cyc;
            if (u == 0) sb10.push_back(e);
            else        sb16.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic waitDone(input int u, input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((u == 0 && done10) || (u == 1 && done16)) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic expT mk(input logic [31:0] q, input logic [31:0] r, input logic z);
        expT e;
        e.q = q; e.r = r; e.z = z; e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done10) begin
            if (sb10.size() == 0) begin
                checkOutput("dut10_unexpected_done", 32'd1, 32'd0);
            end else begin
                expT e;
                e = sb10.pop_front();
                checkOutput("dut10_quotient", 32'(q10), e.q);
                checkOutput("dut10_remainder", 32'(r10), e.r);
                checkOutput("dut10_div_by_zero", 32'(z10), 32'(e.z));
                checkOutput("dut10_latency", 32'(cyc - e.cyc), 32'd11);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done16) begin
            if (sb16.size() == 0) begin
                checkOutput("dut16_unexpected_done", 32'd1, 32'd0);
            end else begin
                expT e;
                e = sb16.pop_front();
                checkOutput("dut16_quotient", 32'(q16), e.q);
                checkOutput("dut16_remainder", 32'(r16), e.r);
                checkOutput("dut16_div_by_zero", 32'(z16), 32'(e.z));
                checkOutput("dut16_latency", 32'(cyc - e.cyc), 32'd17);
            end
        end
    end

    initial begin
        bit          got;
        bit          bad;
        logic [31:0] a;
        logic [31:0] b;
        bit          sm;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready10", 32'(ready10), 32'd1);
        checkOutput("reset_done10", 32'(done10), 32'd0);
        checkOutput("reset_q10", 32'(q10), 32'd0);
        checkOutput("reset_r10", 32'(r10), 32'd0);
        checkOutput("reset_z10", 32'(z10), 32'd0);
        checkOutput("reset_ready16", 32'(ready16), 32'd1);
        checkOutput("reset_q16", 32'(q16), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic unsigned case, with ready low throughout RUN/FIX.
        applyStimulus(0, 1'b0, 32'd1000, 32'd7, mk(32'd142, 32'd6, 1'b0));
        bad = 1'b0;
        for (int i = 0; i < 11; i++) begin
            if (ready10 || done10) bad = 1'b1;
            @(negedge clk);
        end
        checkOutput("t1_ready_low_busy", 32'(bad), 32'd0);
        waitDone(0, 2, got);
        checkOutput("t1_done_seen", 32'(got), 32'd1);
        checkOutput("t1_ready_with_done", 32'(ready10), 32'd1);

        applyStimulus(0, 1'b1, 32'h3F9, 32'd2, mk(32'h3FD, 32'h3FF, 1'b0));
        waitDone(0, 20, got);
        checkOutput("t2a_done_seen", 32'(got), 32'd1);
        applyStimulus(0, 1'b1, 32'd7, 32'h3FE, mk(32'h3FD, 32'd1, 1'b0));
        waitDone(0, 20, got);
        checkOutput("t2b_done_seen", 32'(got), 32'd1);
        applyStimulus(0, 1'b1, 32'h200, 32'h3FF, mk(32'h200, 32'd0, 1'b0));
        waitDone(0, 20, got);
        checkOutput("t2c_done_seen", 32'(got), 32'd1);
        applyStimulus(0, 1'b0, 32'h3F9, 32'd2, mk(32'd508, 32'd1, 1'b0));
        waitDone(0, 20, got);
        checkOutput("t2d_done_seen", 32'(got), 32'd1);

        applyStimulus(0, 1'b0, 32'd513, 32'd0, mk(32'h3FF, 32'd513, 1'b1));
        waitDone(0, 20, got);
        checkOutput("t3a_done_seen", 32'(got), 32'd1);
        applyStimulus(0, 1'b1, 32'h3FB, 32'd0, mk(32'h3FF, 32'h3FB, 1'b1));
        waitDone(0, 20, got);
        checkOutput("t3b_done_seen", 32'(got), 32'd1);

        // Back-to-back starts, results held, mid-RUN start ignored.
        applyStimulus(0, 1'b0, 32'd100, 32'd9, mk(32'd11, 32'd1, 1'b0));
        waitDone(0, 20, got);
        checkOutput("t4_first_done", 32'(got), 32'd1);
        applyStimulus(0, 1'b0, 32'd255, 32'd16, mk(32'd15, 32'd15, 1'b0));
        for (int i = 0; i < 11; i++) begin
            if (i == 3 || i == 9) begin
                checkOutput("t4_held_q", 32'(q10), 32'd11);
                checkOutput("t4_held_r", 32'(r10), 32'd1);
            end
            if (i == 4) begin
                start10 = 1'b1; dvd10 = 10'd5; dvs10 = 10'd1;
            end
            if (i == 5) start10 = 1'b0;
            @(negedge clk);
        end
        waitDone(0, 2, got);
        checkOutput("t4_second_done", 32'(got), 32'd1);
        @(negedge clk);
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done10) bad = 1'b1;
            @(negedge clk);
        end
        checkOutput("t4_no_extra_done", 32'(bad), 32'd0);

        // Reset mid-operation aborts without a done pulse.
        applyStimulus(0, 1'b0, 32'd1000, 32'd7, mk(32'd142, 32'd6, 1'b0));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb10.delete();
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t5_ready_after_rst", 32'(ready10), 32'd1);
        checkOutput("t5_q_after_rst", 32'(q10), 32'd0);
        checkOutput("t5_r_after_rst", 32'(r10), 32'd0);
        checkOutput("t5_z_after_rst", 32'(z10), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done10) bad = 1'b1;
            @(negedge clk);
        end
        checkOutput("t5_no_done_after_abort", 32'(bad), 32'd0);

        rst = 1'b1; start10 = 1'b1; dvd10 = 10'd1000; dvs10 = 10'd7;
        @(posedge clk);
        #1;
        start10 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_beats_start", 32'(ready10), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done10) bad = 1'b1;
            @(negedge clk);
        end
        checkOutput("t5_no_done_rst_start", 32'(bad), 32'd0);

        // 16-bit unsigned-only unit ignores signed_mode.
        applyStimulus(1, 1'b1, 32'hFFF9, 32'd2, mk(32'd32764, 32'd1, 1'b0));
        waitDone(1, 30, got);
        checkOutput("t6_dut16_done", 32'(got), 32'd1);

        for (int n = 0; n < 2000; n++) begin
            a  = pick(10);
            b  = pick(10);
            sm = 1'($urandom_range(0, 1));
            applyStimulus(0, sm, a, b, model(10, sm, a, b));
            waitDone(0, 20, got);
            if (!got) begin
                checkOutput("rand10_timeout", 32'd0, 32'd1);
                break;
            end
        end

        for (int n = 0; n < 1500; n++) begin
            a  = pick(16);
            b  = pick(16);
            sm = 1'($urandom_range(0, 1));
            applyStimulus(1, sm, a, b, model(16, 1'b0, a, b));
            waitDone(1, 30, got);
            if (!got) begin
                checkOutput("rand16_timeout", 32'd0, 32'd1);
                break;
            end
        end

        repeat (3) @(negedge clk);
        checkOutput("sb10_drained", 32'(sb10.size()), 32'd0);
        checkOutput("sb16_drained", 32'(sb16.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
